string_led_receiver: RTL
========================

STRING_LED_RECEIVER -- requirements
Module: string_led_receiver

Interface
REQ-001 SHALL have parameter BIT_THRESH, default 20: high-pulse length in clocks at or above which a bit decodes as 1.
REQ-002 SHALL have parameter MIN_HIGH, default 4: high pulses shorter than this are glitch errors.
REQ-003 SHALL have parameter MAX_HIGH, default 60: high pulses longer than this are errors.
REQ-004 SHALL have parameter RESET_CYCLES, default 2000, legal range 2..4095: consecutive low clocks that constitute a latch/reset gap.
REQ-005 wb_clk_i  input  1  sole clock; one clock domain; reset is synchronous and active-high.
REQ-006 wb_rst_i  input  1  synchronous, active-high reset.
REQ-007 din  input  1  asynchronous one-wire LED data stream (WS2812-style NRZ pulse-width code).
REQ-008 dout  output  1  downstream data; forwards the stream after this stage has taken its pixel.
REQ-009 pixel_data  output  24  last captured pixel, first-received bit in [23] (G[7:0], R[7:0], B[7:0] order as on wire).
REQ-010 pixel_valid  output  1  one-clock pulse when pixel_data updates.
REQ-011 frame_end  output  1  one-clock pulse on detection of a reset gap.
REQ-012 rx_error  output  1  one-clock pulse on a pulse-width violation.

Function
REQ-013 din SHALL pass through a 2-flop synchronizer; all timing below refers to synchronized din_s, 2-clock input latency.
REQ-014 high_cnt (8 bit) and low_cnt (12 bit) SHALL count consecutive high/low clocks of din_s, saturating at all-ones, clearing on the opposite level.
REQ-015 States SHALL be SYNC, RX, FORWARD.
REQ-016 SYNC: ignore pulses, dout=0; go to RX when a reset gap is detected.
REQ-017 Reset gap SHALL be detected on the clock where din_s is low for the RESET_CYCLES-th consecutive clock; it pulses frame_end exactly once per gap, in every state.
REQ-018 On reset gap from any state: bit_cnt cleared, partial shift register discarded, state becomes RX.
REQ-019 RX: on each falling edge of din_s, the completed high pulse (length H = high_cnt) SHALL decode: H<MIN_HIGH or H>MAX_HIGH -> error; H>=BIT_THRESH -> 1; else 0.
REQ-020 Decoded bits SHALL shift in MSB-first; bit_cnt (5 bit) counts 0..23.
REQ-021 On the 24th valid bit, pixel_data SHALL load the full word and pixel_valid SHALL pulse one clock after the falling edge of din_s; state becomes FORWARD.
REQ-022 FORWARD: dout SHALL equal din_s delayed one clock; no decoding; pixel_data held.
REQ-023 On error in RX: rx_error pulses one clock after the falling edge, partial pixel discarded, pixel_data unchanged, state becomes SYNC.
REQ-024 In RX/SYNC dout SHALL be 0; the stage SHALL never forward its own 24 bits.
REQ-025 A high pulse still in progress when high_cnt exceeds MAX_HIGH SHALL be flagged at its falling edge only (single rx_error pulse).
REQ-026 Low gaps shorter than RESET_CYCLES between bits SHALL be legal regardless of length.
REQ-027 If reset-gap detection and a falling edge coincide (impossible since din_s is low for the gap) no special handling is required; a rising edge on the same clock as the RESET_CYCLES-th low is not possible by construction.

Reset
REQ-028 While wb_rst_i is high at a clock edge: state=SYNC, counters and shift register 0, sync flops 0, pixel_data=24'h000000, dout=0, pixel_valid=0, frame_end=0, rx_error=0.
REQ-029 Reset asserted mid-pixel SHALL discard the partial pixel; after release a fresh reset gap is required before decoding.
REQ-030 Reset SHALL take priority over all other events in the same clock.

Verification
REQ-031 Idle low 2000 clocks, then 24 bits of 0xFF0055 (1=28 high/22 low, 0=14 high/36 low) -> frame_end once, pixel_valid once, pixel_data=24'hFF0055, dout=0 throughout.
REQ-032 Gap, 48 bits (0x123456 then 0xABCDEF) -> pixel_data=24'h123456, dout reproduces second 24 pulses delayed 3 clocks from din, widths preserved.
REQ-033 Gap, 10 valid bits, 2-clock high glitch -> rx_error single pulse, no pixel_valid; subsequent bits ignored until next 2000-clock gap; then 0x00FF00 -> pixel_data=24'h00FF00.
REQ-034 Gap, 12 bits, low for 1999 clocks, 12 more bits -> no frame_end, pixel assembled from all 24 bits; low 2000 clocks -> frame_end pulse exactly on the 2000th low clock of din_s.
REQ-035 Gap, 70-clock high pulse -> rx_error at its falling edge, state SYNC.
REQ-036 wb_rst_i pulsed after 15 bits -> outputs zero; next 24 bits without gap ignored; after gap a new pixel decodes correctly.

Source files
------------

// File: rtl/string_led_receiver.sv
// rtl/string_led_receiver.sv - WS2812-style one-wire LED pixel receiver with downstream forwarding
module string_led_receiver #(
  parameter int BIT_THRESH   = 20,
  parameter int MIN_HIGH     = 4,
  parameter int MAX_HIGH     = 60,
  parameter int RESET_CYCLES = 2000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        din,
  output logic        dout,
  output logic [23:0] pixel_data,
  output logic        pixel_valid,
  output logic        frame_end,
  output logic        rx_error
);

  typedef enum logic [1:0] {SYNC, RX, FORWARD} state_t;

  localparam logic [11:0] GAP_CNT = 12'(RESET_CYCLES - 1);
  localparam logic [7:0]  THR     = 8'(BIT_THRESH);
  localparam logic [7:0]  MIN_H   = 8'(MIN_HIGH);
  localparam logic [7:0]  MAX_H   = 8'(MAX_HIGH);

  state_t      state, state_next;
  logic        din_m, din_s, din_d;
  logic [7:0]  high_cnt;
  logic [11:0] low_cnt;
  logic [4:0]  bit_cnt;
  logic [22:0] shreg;
  logic        fall, gap, bit_val, bit_bad;
  logic        shift_en, load_pix, err;

  // high_cnt still holds the completed pulse length on the clock din_s drops
  assign fall      = din_d & ~din_s;
  assign gap       = ~din_s && (low_cnt == GAP_CNT);
  assign frame_end = gap;
  assign bit_bad   = (high_cnt < MIN_H) || (high_cnt > MAX_H);
  assign bit_val   = (high_cnt >= THR);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state <= SYNC;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    shift_en   = 1'b0;
    load_pix   = 1'b0;
    err        = 1'b0;
    if (gap) begin
      state_next = RX;
    end else begin
      case (state)
        RX: begin
          if (fall) begin
            if (bit_bad) begin
              err        = 1'b1;
              state_next = SYNC;
            end else if (bit_cnt == 5'd23) begin
              load_pix   = 1'b1;
              state_next = FORWARD;
            end else begin
              shift_en = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      din_m       <= 1'b0;
      din_s       <= 1'b0;
      din_d       <= 1'b0;
      high_cnt    <= 8'd0;
      low_cnt     <= 12'd0;
      bit_cnt     <= 5'd0;
      shreg       <= 23'd0;
      pixel_data  <= 24'h000000;
      pixel_valid <= 1'b0;
      rx_error    <= 1'b0;
      dout        <= 1'b0;
    end else begin
      din_m <= din;
      din_s <= din_m;
      din_d <= din_s;

      if (!din_s)                 high_cnt <= 8'd0;
      else if (high_cnt != 8'hFF) high_cnt <= high_cnt + 8'd1;

      if (din_s)                    low_cnt <= 12'd0;
      else if (low_cnt != 12'hFFF)  low_cnt <= low_cnt + 12'd1;

      pixel_valid <= load_pix;
      rx_error    <= err;
      dout        <= (state == FORWARD) & din_s;

      if (gap || err) begin
        bit_cnt <= 5'd0;
        shreg   <= 23'd0;
      end else if (load_pix) begin
        pixel_data <= {shreg, bit_val};
        bit_cnt    <= 5'd0;
        shreg      <= 23'd0;
      end else if (shift_en) begin
        shreg   <= {shreg[21:0], bit_val};
        bit_cnt <= bit_cnt + 5'd1;
      end
    end
  end

endmodule
